// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared definitions for the divider arbiter.
//   lat()         number of divider stages for an N/M divider (one quotient bit each)
//   tag_w()       requester tag width for a given requester count
//   tag_stage_t   one slot of the tag pipeline that travels beside the divider
// Optional feature macro: DIV_ARB_DIV0_FLAG_EN adds a div0 bit to each tag slot.
package div_arb_pkg;

    function automatic int lat(input int n, input int m);
        return n - m + 1;
    endfunction

    function automatic int tag_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // The struct lives in the package, so its tag field is sized for the
    // largest supported requester count; smaller configurations leave the
    // upper tag bits at zero.
    localparam int MAX_NREQ = 8;
    localparam int TAG_W    = tag_w(MAX_NREQ);

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
`ifdef DIV_ARB_DIV0_FLAG_EN
        logic             div0;
`endif
    } tag_stage_t;

endpackage

// File: rtl/div_pipe.sv
// div_pipe: LAT-stage divider_cell chain with the requester tag pipeline
// beside it. Everything advances every cycle; there are no stalls.
//   en/dividend/divisor  issue-register outputs feeding stage 1
//   tag_in               tag slot entering with the operands
//   quotient/remainder   last-stage results
//   tag_out              tag slot aligned with quotient/remainder
module div_pipe
    import div_arb_pkg::*;
#(
    parameter int N = 16,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    input  tag_stage_t   tag_in,
    output logic [N-M:0] quotient,
    output logic [M-1:0] remainder,
    output tag_stage_t   tag_out
);

    localparam int STAGES = lat(N, M);
    localparam int QW     = N - M + 1;
    localparam int LW     = N - M;

    // Index k is the input of cell k; index k+1 is its registered output.
    logic [STAGES:0]         rdy;
    logic [STAGES:0][QW-1:0] merch;
    logic [STAGES:0][M-1:0]  dvs;
    logic [STAGES:0][LW-1:0] kp;
    logic [STAGES:1][M-1:0]  rem;

    assign rdy[0]   = en;
    assign merch[0] = '0;
    assign dvs[0]   = divisor;
    assign kp[0]    = dividend[LW-1:0];

    for (genvar k = 0; k < STAGES; k++) begin : g_cell
        logic [M:0] cell_dvd;
        if (k == 0) begin : g_first
            assign cell_dvd = {1'b0, dividend[N-1:LW]};
        end else begin : g_rest
            // bring down the next dividend bit, MSB first
            assign cell_dvd = {rem[k], kp[k][LW-k]};
        end
        divider_cell #(.N(N), .M(M)) u_cell (
            .clk         (clk),
            .rst         (rst),
            .en          (rdy[k]),
            .dividend    (cell_dvd),
            .divisor     (dvs[k]),
            .merchant_ci (merch[k]),
            .dividend_ci (kp[k]),
            .rdy         (rdy[k+1]),
            .merchant    (merch[k+1]),
            .remainder   (rem[k+1]),
            .divisor_kp  (dvs[k+1]),
            .dividend_kp (kp[k+1])
        );
    end

    // Last-stage forwarding outputs have no consumer; the tag slot carries validity.
    logic unused_tail;
    assign unused_tail = ^{rdy[STAGES], dvs[STAGES], kp[STAGES]};

    assign quotient  = merch[STAGES];
    assign remainder = rem[STAGES];

    tag_stage_t [STAGES:1] tag_q;

    always_ff @(posedge clk) begin
        if (rst) tag_q <= '0;
        else     tag_q <= {tag_q[STAGES-1:1], tag_in};
    end

    assign tag_out = tag_q[STAGES];

endmodule

// File: rtl/divider_cell.sv
// divider_cell: one registered restoring-division stage.
//   en/rdy        stage valid in / registered valid out
//   dividend      M+1-bit partial remainder with the next dividend bit appended
//   divisor       divisor, forwarded as divisor_kp
//   merchant_ci   quotient bits so far; merchant = merchant_ci shifted left + this bit
//   dividend_ci   remaining low dividend bits, forwarded as dividend_kp
//   remainder     partial remainder after this stage
module divider_cell #(
    parameter int N = 16,
    parameter int M = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [M:0]     dividend,
    input  logic [M-1:0]   divisor,
    input  logic [N-M:0]   merchant_ci,
    input  logic [N-M-1:0] dividend_ci,
    output logic           rdy,
    output logic [N-M:0]   merchant,
    output logic [M-1:0]   remainder,
    output logic [M-1:0]   divisor_kp,
    output logic [N-M-1:0] dividend_kp
);

    logic       ge;
    logic [M:0] diff;

    assign ge   = dividend >= {1'b0, divisor};
    assign diff = dividend - {1'b0, divisor};

    // The top quotient bit is shifted out and the subtraction result always
    // fits in M bits when ge is set, so these bits carry nothing.
    logic unused_bits;
    assign unused_bits = ^{merchant_ci[N-M], diff[M]};

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy         <= 1'b0;
            merchant    <= '0;
            remainder   <= '0;
            divisor_kp  <= '0;
            dividend_kp <= '0;
        end else begin
            rdy <= en;
            if (en) begin
                merchant    <= {merchant_ci[N-M-1:0], ge};
                remainder   <= ge ? diff[M-1:0] : dividend[M-1:0];
                divisor_kp  <= divisor;
                dividend_kp <= dividend_ci;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one pipelined restoring divider
// between NREQ requesters, with per-requester in-flight limits.
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester request and combinational grant
//   req_dividend/divisor     packed operands, requester i at [i*N +: N] / [i*M +: M]
//   rsp_valid                one-hot result strobe, LAT+1 cycles after transfer
//   rsp_quotient/remainder   shared result bus, zero when no response
//   rsp_div0                 divide-by-zero flag (only with DIV_ARB_DIV0_FLAG_EN)
//   busy                     some division is in flight
// Optional feature macro: DIV_ARB_DIV0_FLAG_EN.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int N       = 16,
    parameter int M       = 8,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_dividend,
    input  logic [NREQ*M-1:0] req_divisor,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [N-M:0]      rsp_quotient,
    output logic [M-1:0]      rsp_remainder,
`ifdef DIV_ARB_DIV0_FLAG_EN
    output logic              rsp_div0,
`endif
    output logic              busy
);

    localparam int QW = N - M + 1;
    localparam int TW = tag_w(NREQ);
    localparam int CW = $clog2(MAX_OUT + 1);

    logic [NREQ-1:0][CW-1:0] out_cnt;
    logic [TW-1:0]           ptr;
    logic [TW-1:0]           gidx;
    logic                    xfer;
    logic [NREQ-1:0]         elig;

    logic          iss_vld;
    logic [TW-1:0] iss_tag;
    logic [N-1:0]  iss_dvd;
    logic [M-1:0]  iss_dvs;

    tag_stage_t    tag_in;
    tag_stage_t    tag_out;
    logic [QW-1:0] pipe_q;
    logic [M-1:0]  pipe_r;

    // A full requester is released in the same cycle its result returns,
    // so one slot frees and refills without a bubble.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++)
            elig[i] = req_valid[i] && ((out_cnt[i] < CW'(MAX_OUT)) || rsp_valid[i]);
    end

    // Search starts at ptr and wraps; first eligible requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        req_ready = '0;
        gidx      = '0;
        xfer      = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!xfer && elig[idx]) begin
                xfer = 1'b1;
                gidx = TW'(idx);
            end
        end
        if (xfer) req_ready[gidx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_vld <= 1'b0;
            iss_tag <= '0;
            iss_dvd <= '0;
            iss_dvs <= '0;
            ptr     <= '0;
        end else begin
            iss_vld <= xfer;
            if (xfer) begin
                iss_tag <= gidx;
                iss_dvd <= req_dividend[int'(gidx)*N +: N];
                iss_dvs <= req_divisor[int'(gidx)*M +: M];
                ptr     <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
            end
        end
    end

    // A grant always transfers (eligibility implies valid).
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                case ({req_ready[i], rsp_valid[i]})
                    2'b10:   out_cnt[i] <= out_cnt[i] + 1'b1;
                    2'b01:   if (out_cnt[i] != '0) out_cnt[i] <= out_cnt[i] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        tag_in     = '0;
        tag_in.vld = iss_vld;
        tag_in.tag = TAG_W'(iss_tag);
`ifdef DIV_ARB_DIV0_FLAG_EN
        tag_in.div0 = iss_vld && (iss_dvs == '0);
`endif
    end

    div_pipe #(.N(N), .M(M)) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .en        (iss_vld),
        .dividend  (iss_dvd),
        .divisor   (iss_dvs),
        .tag_in    (tag_in),
        .quotient  (pipe_q),
        .remainder (pipe_r),
        .tag_out   (tag_out)
    );

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++)
            rsp_valid[i] = tag_out.vld && (tag_out.tag == TAG_W'(i));
        rsp_quotient  = tag_out.vld ? pipe_q : '0;
        rsp_remainder = tag_out.vld ? pipe_r : '0;
`ifdef DIV_ARB_DIV0_FLAG_EN
        rsp_div0 = tag_out.vld && tag_out.div0;
        if (rsp_div0) begin
            rsp_quotient  = '1;
            rsp_remainder = '0;
        end
`endif
    end

    assign busy = |out_cnt;

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;

    localparam int NREQ    = 3;
    localparam int N       = 16;
    localparam int M       = 8;
    localparam int MAX_OUT = 4;
    localparam int LAT     = N - M + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_dividend;
    logic [NREQ*M-1:0] req_divisor;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [N-M:0]      rsp_quotient;
    logic [M-1:0]      rsp_remainder;
`ifdef DIV_ARB_DIV0_FLAG_EN
    logic              rsp_div0;
`endif
    logic              busy;

    always #5 clk = ~clk;

    div_arbiter #(.NREQ(NREQ), .N(N), .M(M), .MAX_OUT(MAX_OUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
`ifdef DIV_ARB_DIV0_FLAG_EN
        .rsp_div0      (rsp_div0),
`endif
        .busy          (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model state: operands, rr pointer, in-flight counts, expected results
    int opa[NREQ];
    int opb[NREQ];
    int ptr_m;
    int cnt_m[NREQ];

    typedef struct {
        int cyc;
        int rq;
        int q;
        int r;
        bit z;
    } exp_t;
    exp_t expq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic ref_div(input int a, input int b, output int q, output int r, output bit z);
        if (b == 0) begin
            z = 1'b1;
            q = (1 << (N - M + 1)) - 1;
`ifdef DIV_ARB_DIV0_FLAG_EN
            r = 0;
`else
            r = a % (1 << M);
`endif
        end else begin
            z = 1'b0;
            q = a / b;
            r = a % b;
        end
    endtask

    // Operands keep the quotient within N-M+1 bits; divisor 0 about 1 in 16.
    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            int lim;
            opb[i] = ($urandom_range(15) == 0) ? 0 : $urandom_range(255, 1);
            lim    = (opb[i] == 0 || opb[i] * 512 > 65536) ? 65536 : opb[i] * 512;
            opa[i] = $urandom % lim;
        end
    endtask

    // One clock cycle: drive after the edge, check mid-cycle, then advance the model.
    task automatic step(input bit r, input logic [NREQ-1:0] v);
        exp_t e;
        bit has;
        int g;
        int q, rm;
        bit z;
        bit any;
        logic [NREQ-1:0] er, eg;
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            req_dividend[i*N +: N] = N'(opa[i]);
            req_divisor[i*M +: M]  = M'(opb[i]);
        end
        #4;
        if (r) begin
            expq.delete();
            ptr_m = 0;
            for (int i = 0; i < NREQ; i++) cnt_m[i] = 0;
        end else begin
            has = 1'b0;
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                e   = expq.pop_front();
                has = 1'b1;
            end
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (ptr_m + k) % NREQ;
                if (g < 0 && v[i] && (cnt_m[i] < MAX_OUT || (has && e.rq == i))) g = i;
            end
            er  = has ? (NREQ'(1) << e.rq) : '0;
            eg  = (g >= 0) ? (NREQ'(1) << g) : '0;
            any = 1'b0;
            for (int i = 0; i < NREQ; i++) if (cnt_m[i] > 0) any = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(eg));
            chk("rsp_valid", 32'(rsp_valid), 32'(er));
            chk("rsp_quotient", 32'(rsp_quotient), has ? e.q : 0);
            chk("rsp_remainder", 32'(rsp_remainder), has ? e.r : 0);
            chk("busy", 32'(busy), 32'(any));
`ifdef DIV_ARB_DIV0_FLAG_EN
            chk("rsp_div0", 32'(rsp_div0), (has && e.z) ? 1 : 0);
`endif
            if (has) cnt_m[e.rq]--;
            if (g >= 0) begin
                ref_div(opa[g], opb[g], q, rm, z);
                expq.push_back('{cyc: cyc + LAT + 1, rq: g, q: q, r: rm, z: z});
                cnt_m[g]++;
                ptr_m = (g + 1) % NREQ;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        ptr_m        = 0;
        for (int i = 0; i < NREQ; i++) begin
            opa[i]   = 0;
            opb[i]   = 1;
            cnt_m[i] = 0;
        end

        step(1'b1, '0);
        step(1'b1, '0);
        idle(2);

        // single request 1000/7 from requester 0
        opa[0] = 1000; opb[0] = 7;
        step(1'b0, 3'b001);
        idle(LAT + 3);

        // everyone valid every cycle
        for (int i = 0; i < 30; i++) begin rand_ops(); step(1'b0, 3'b111); end
        idle(LAT + 3);

        // requester 1 alone: fills to MAX_OUT, stalls, released on first result
        for (int i = 0; i < 26; i++) begin rand_ops(); step(1'b0, 3'b010); end
        idle(LAT + 3);

        // requester 2 alone: transfer and response coincide at the limit
        for (int i = 0; i < 26; i++) begin rand_ops(); step(1'b0, 3'b100); end
        idle(LAT + 3);

        // divide by zero
        opa[0] = 500; opb[0] = 0;
        step(1'b0, 3'b001);
        idle(LAT + 3);

        // random traffic
        for (int i = 0; i < 300; i++) begin rand_ops(); step(1'b0, NREQ'($urandom)); end
        idle(LAT + 3);

        // reset with divisions in flight: none may come back
        for (int i = 0; i < 3; i++) begin rand_ops(); step(1'b0, 3'b111); end
        idle(4);
        step(1'b1, '0);
        idle(20);
        rand_ops();
        step(1'b0, 3'b111);
        idle(LAT + 3);

        chk("drained", 32'(expq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
